// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word access through a word-wide data memory.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses respond with an error.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        misal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    assign mem_read       = (state == RD);
    assign mem_write      = (state == WR);
    assign mem_addr       = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_write_data = mem_write ? wdata_q : 32'd0;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misal = 1'b0;
        case (req_funct3[1:0])
            2'b00:   misal = 1'b0;
            2'b01:   misal = req_addr[0];
            default: misal = |req_addr[1:0];
        endcase
    end

    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (accept)
            err_q <= misal;
    end
    assign resp_err = err_q;
`else
    assign misal    = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Half lane uses addr[1] only, so addr[0] is ignored for H/HU/SH.
    always_comb begin
        ld_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_read_data;
        endcase
    end

    always_comb begin
        st_word = mem_read_data;
        if (f3_q[1:0] == 2'b00)
            st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (f3_q[1:0] == 2'b01)
            st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (misal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_we && req_funct3[1]) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        wdata_q <= st_word;
                        state   <= WR;
                    end else begin
                        resp_rdata <= ld_data;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_rdata <= 32'd0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: none; all widths are fixed as listed below.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  CPU access request present.
REQ-005 req_ready  out  1  unit idle; request accepted when req_valid&&req_ready at a rising edge.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-011 resp_rdata  out  32  load result, extended; 0 for stores.
REQ-012 resp_err  out  1  misaligned access flag, valid with resp_valid.
REQ-013 mem_addr  out  32  word address to data memory; bits[1:0] always 0.
REQ-014 mem_write_data  out  32  full word to data memory.
REQ-015 mem_read  out  1  read enable; data memory returns read_data combinationally.
REQ-016 mem_write  out  1  write enable; data memory writes on the rising edge.
REQ-017 mem_read_data  in  32  word from data memory.

Function
REQ-018 FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-019 On accept, the unit latches we, funct3, addr and wdata; later req_* changes are ignored until the next accept.
REQ-020 Accepted load or sub-word store: IDLE->RD; word store: IDLE->WR.
REQ-021 In RD, mem_read=1 and mem_read_data is captured at the edge; load: RD->RESP; SB/SH: RD->WR.
REQ-022 In WR, mem_write=1 for exactly one cycle; WR->RESP.
REQ-023 In RESP, resp_valid=1 for one cycle; RESP->IDLE.
REQ-024 Latency from accept edge to resp_valid: LW/LB/LH/LBU/LHU 2 cycles; SW 2 cycles; SB/SH 3 cycles.
REQ-025 Back-to-back: the next request is accepted no earlier than the first IDLE cycle after RESP.
REQ-026 mem_read, mem_write, mem_addr and mem_write_data are 0 outside RD/WR.
REQ-027 Loads select byte addr[1:0] or halfword addr[1], little-endian; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-028 SB merges wdata[7:0] into lane addr[1:0] of the captured word; SH merges wdata[15:0] into half addr[1]; other lanes are unchanged.
REQ-029 Load funct3 011/110/111 is treated as W; store funct3[2] is ignored and 011 is treated as W.
REQ-030 resp_rdata is held stable from RESP until the next RESP.

Reset
REQ-031 rst asynchronously forces: state IDLE; resp_valid 0, resp_rdata 0, resp_err 0; mem_read 0, mem_write 0 (mem_write is driven from registered state so it drops within the same cycle).
REQ-032 No request is accepted while rst is high; req_ready is 1 in the first cycle after rst falls.
REQ-033 Reset mid-operation abandons the access with no response; a pending WR is not issued.

Configuration
REQ-034 Macro MISALIGN_TRAP_EN.
REQ-035 When defined: H/HU/SH with addr[0]=1, or W with addr[1:0]!=0, go IDLE->RESP with no mem_read/mem_write; resp_err=1, resp_rdata=0; latency 1 cycle.
REQ-036 When undefined: resp_err is tied to 0; the ignored low address bits are forced to 0 (H on half addr[1], W on word); timing as in REQ-024.

Verification
REQ-037 Memory word 0x10=0x80FF7F01; LW 0x10 -> resp_valid 2 cycles after accept, rdata 0x80FF7F01, one mem_read cycle.
REQ-038 Same word: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x12 -> 0x000080FF; LB 0x10 -> 0x00000001.
REQ-039 Word 0x10=0x11223344; SB 0x11 with wdata 0x000000AB -> one RD cycle, then one WR with mem_write_data 0x1122AB44; resp at 3 cycles; a following LW reads 0x1122AB44.
REQ-040 LW 0x12 with MISALIGN_TRAP_EN -> resp_err=1, rdata 0 after 1 cycle, mem_read/mem_write never asserted; without the macro -> reads word 0x10, resp_err=0.
REQ-041 SH 0x10 with rst pulsed during WR -> mem_write drops in the same cycle, memory unchanged, no resp_valid, req_ready=1 the cycle after rst falls.
REQ-042 req_valid held high with SW then LW -> second accept in the IDLE cycle after resp_valid; no overlap of mem_read and mem_write.
